// File: rtl/mandel_frame_ctrl.sv
// Frame-level controller for the Mandelbrot pixel core.
// Keeps a software-written shadow parameter set and transfers it to the core
// only at frame boundaries, sequences start/stop of generation without ever
// truncating a frame, optionally auto-pans the offsets once per frame, and
// reports frame completion, frame count and status.
module mandel_frame_ctrl #(
    parameter int ITER_W   = 9,
    parameter int ZOOM_W   = 3,
    parameter int OFF_W    = 25,
    parameter int DEF_ITER = 100,
    parameter int MAX_ZOOM = 7,
    parameter int CNT_W    = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     ctrl_start,
    input  logic                     ctrl_stop,
    input  logic                     cfg_commit,
    input  logic [ITER_W-1:0]        cfg_iter,
    input  logic [ZOOM_W-1:0]        cfg_zoom,
    input  logic signed [OFF_W-1:0]  cfg_x_off,
    input  logic signed [OFF_W-1:0]  cfg_y_off,
    input  logic                     cfg_auto_en,
    input  logic signed [OFF_W-1:0]  cfg_x_step,
    input  logic signed [OFF_W-1:0]  cfg_y_step,
    input  logic                     pix_valid,
    input  logic                     pix_ready,
    input  logic                     pix_last_x,
    input  logic                     pix_last_y,
    output logic                     gen_enable,
    output logic [ITER_W-1:0]        iterations_max,
    output logic [ZOOM_W-1:0]        zoom,
    output logic signed [OFF_W-1:0]  x_offset,
    output logic signed [OFF_W-1:0]  y_offset,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic                     cfg_pending,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic signed [OFF_W-1:0] OFF_MAX = {1'b0, {(OFF_W-1){1'b1}}};
    localparam logic signed [OFF_W-1:0] OFF_MIN = {1'b1, {(OFF_W-1){1'b0}}};
    localparam logic [ITER_W-1:0]       ITER_RST = ITER_W'(DEF_ITER);

    // Zero iterations would make the core emit nothing useful; force at least one.
    function automatic logic [ITER_W-1:0] sanitize_iter(input logic [ITER_W-1:0] v);
        return (v == '0) ? ITER_W'(1) : v;
    endfunction

    // The core only supports zoom levels up to MAX_ZOOM.
    function automatic logic [ZOOM_W-1:0] clamp_zoom(input logic [ZOOM_W-1:0] v);
        return (int'(v) > MAX_ZOOM) ? ZOOM_W'(MAX_ZOOM) : v;
    endfunction

    // Signed add that pins at the representable extremes instead of wrapping,
    // so a long auto-pan parks at the edge of the plane.
    function automatic logic signed [OFF_W-1:0] sat_add(input logic signed [OFF_W-1:0] a,
                                                       input logic signed [OFF_W-1:0] b);
        logic signed [OFF_W:0] sum;
        sum = {a[OFF_W-1], a} + {b[OFF_W-1], b};
        if (sum[OFF_W] != sum[OFF_W-1]) begin
            return sum[OFF_W] ? OFF_MIN : OFF_MAX;
        end
        return sum[OFF_W-1:0];
    endfunction

    state_t state;
    state_t state_nxt;

    logic                    fend;
    logic [ITER_W-1:0]       cm_iter;
    logic [ZOOM_W-1:0]       cm_zoom;

    logic [ITER_W-1:0]       sh_iter;
    logic [ZOOM_W-1:0]       sh_zoom;
    logic signed [OFF_W-1:0] sh_x_off;
    logic signed [OFF_W-1:0] sh_y_off;
    logic                    sh_auto_en;
    logic signed [OFF_W-1:0] sh_x_step;
    logic signed [OFF_W-1:0] sh_y_step;

    // A frame ends only when the last pixel of the last line is actually accepted.
    assign fend    = pix_valid & pix_ready & pix_last_x & pix_last_y;
    assign cm_iter = sanitize_iter(cfg_iter);
    assign cm_zoom = clamp_zoom(cfg_zoom);
    assign busy    = (state != ST_IDLE);

    // Run/stop sequencing; a stop request only takes effect at a frame end.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (ctrl_stop) state_nxt = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (fend)            state_nxt = ST_IDLE;
                else if (ctrl_start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and the registered core enable that follows it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            gen_enable <= 1'b0;
        end else begin
            state      <= state_nxt;
            gen_enable <= (state_nxt != ST_IDLE);
        end
    end

    // Shadow capture and frame-boundary transfer to the active parameter set.
    // The commit branch comes last so that, when a commit coincides with a
    // frame end, the old shadow is applied and the new one is left pending.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sh_iter        <= ITER_RST;
            sh_zoom        <= '0;
            sh_x_off       <= '0;
            sh_y_off       <= '0;
            sh_auto_en     <= 1'b0;
            sh_x_step      <= '0;
            sh_y_step      <= '0;
            iterations_max <= ITER_RST;
            zoom           <= '0;
            x_offset       <= '0;
            y_offset       <= '0;
            cfg_pending    <= 1'b0;
        end else begin
            if (fend) begin
                if (cfg_pending) begin
                    iterations_max <= sh_iter;
                    zoom           <= sh_zoom;
                    x_offset       <= sh_x_off;
                    y_offset       <= sh_y_off;
                    cfg_pending    <= 1'b0;
                end else if (sh_auto_en) begin
                    x_offset <= sat_add(x_offset, sh_x_step);
                    y_offset <= sat_add(y_offset, sh_y_step);
                end
            end
            if (cfg_commit) begin
                sh_iter    <= cm_iter;
                sh_zoom    <= cm_zoom;
                sh_x_off   <= cfg_x_off;
                sh_y_off   <= cfg_y_off;
                sh_auto_en <= cfg_auto_en;
                sh_x_step  <= cfg_x_step;
                sh_y_step  <= cfg_y_step;
                if (state == ST_IDLE) begin
                    // Nothing is being generated, so the new set can go live at once.
                    iterations_max <= cm_iter;
                    zoom           <= cm_zoom;
                    x_offset       <= cfg_x_off;
                    y_offset       <= cfg_y_off;
                    cfg_pending    <= 1'b0;
                end else begin
                    cfg_pending    <= 1'b1;
                end
            end
        end
    end

    // Frame-end pulse and wrapping completed-frame counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= fend;
            if (fend) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mandel_frame_ctrl.sv
// Directed bench for mandel_frame_ctrl with a behavioural reference model
// and per-cycle output comparison plus literal checkpoints.
module tb_mandel_frame_ctrl;

    localparam int ITER_W = 9;
    localparam int ZOOM_W = 3;
    localparam int OFF_W  = 25;
    localparam int MAXZ   = 5;
    localparam int CNT_W  = 4;
    localparam int OMAX   = (1 << (OFF_W-1)) - 1;
    localparam int OMIN   = -(1 << (OFF_W-1));

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic ctrl_start = 1'b0, ctrl_stop = 1'b0, cfg_commit = 1'b0;
    logic [ITER_W-1:0] cfg_iter = '0;
    logic [ZOOM_W-1:0] cfg_zoom = '0;
    logic signed [OFF_W-1:0] cfg_x_off = '0, cfg_y_off = '0, cfg_x_step = '0, cfg_y_step = '0;
    logic cfg_auto_en = 1'b0;
    logic pix_valid = 1'b0, pix_ready = 1'b0, pix_last_x = 1'b0, pix_last_y = 1'b0;
    logic gen_enable, frame_done, cfg_pending, busy;
    logic [ITER_W-1:0] iterations_max;
    logic [ZOOM_W-1:0] zoom;
    logic signed [OFF_W-1:0] x_offset, y_offset;
    logic [CNT_W-1:0] frame_cnt;

    mandel_frame_ctrl #(
        .ITER_W(ITER_W), .ZOOM_W(ZOOM_W), .OFF_W(OFF_W),
        .DEF_ITER(100), .MAX_ZOOM(MAXZ), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .cfg_commit(cfg_commit),
        .cfg_iter(cfg_iter), .cfg_zoom(cfg_zoom), .cfg_x_off(cfg_x_off), .cfg_y_off(cfg_y_off),
        .cfg_auto_en(cfg_auto_en), .cfg_x_step(cfg_x_step), .cfg_y_step(cfg_y_step),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last_x(pix_last_x), .pix_last_y(pix_last_y),
        .gen_enable(gen_enable), .iterations_max(iterations_max), .zoom(zoom),
        .x_offset(x_offset), .y_offset(y_offset), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .cfg_pending(cfg_pending), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Run mode: 0 = idle, 1 = running, 2 = finishing last frame before idling.
    int  m_mode = 0;
    int  m_gen = 0, m_iter = 100, m_zoom = 0, m_x = 0, m_y = 0;
    int  m_pend = 0, m_cnt = 0, m_done = 0;
    int  s_iter = 100, s_zoom = 0, s_x = 0, s_y = 0, s_auto = 0, s_xs = 0, s_ys = 0;
    int  t_iter, t_zoom, t_mode;
    bit  t_fend;

    function automatic int clamp_off(input int v);
        if (v > OMAX) return OMAX;
        if (v < OMIN) return OMIN;
        return v;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_mode = 0; m_gen = 0; m_iter = 100; m_zoom = 0; m_x = 0; m_y = 0;
            m_pend = 0; m_cnt = 0; m_done = 0;
            s_iter = 100; s_zoom = 0; s_x = 0; s_y = 0; s_auto = 0; s_xs = 0; s_ys = 0;
        end else begin
            t_fend = pix_valid && pix_ready && pix_last_x && pix_last_y;
            t_iter = (cfg_iter == 0) ? 1 : int'(cfg_iter);
            t_zoom = (int'(cfg_zoom) > MAXZ) ? MAXZ : int'(cfg_zoom);
            m_done = t_fend ? 1 : 0;
            if (t_fend) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (m_pend != 0) begin
                    m_iter = s_iter; m_zoom = s_zoom; m_x = s_x; m_y = s_y; m_pend = 0;
                end else if (s_auto != 0) begin
                    m_x = clamp_off(m_x + s_xs);
                    m_y = clamp_off(m_y + s_ys);
                end
            end
            if (cfg_commit) begin
                s_iter = t_iter; s_zoom = t_zoom; s_x = int'(cfg_x_off); s_y = int'(cfg_y_off);
                s_auto = cfg_auto_en ? 1 : 0; s_xs = int'(cfg_x_step); s_ys = int'(cfg_y_step);
                if (m_mode == 0) begin
                    m_iter = s_iter; m_zoom = s_zoom; m_x = s_x; m_y = s_y; m_pend = 0;
                end else begin
                    m_pend = 1;
                end
            end
            t_mode = m_mode;
            if (m_mode == 0 && ctrl_start) t_mode = 1;
            else if (m_mode == 1 && ctrl_stop) t_mode = 2;
            else if (m_mode == 2 && t_fend) t_mode = 0;
            else if (m_mode == 2 && ctrl_start) t_mode = 1;
            m_mode = t_mode;
            m_gen  = (m_mode != 0) ? 1 : 0;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge aclk) begin
        if (chk_on) begin
            chk("gen_enable", longint'(gen_enable), m_gen);
            chk("busy", longint'(busy), (m_mode != 0) ? 1 : 0);
            chk("iterations_max", longint'(iterations_max), m_iter);
            chk("zoom", longint'(zoom), m_zoom);
            chk("x_offset", longint'(x_offset), m_x);
            chk("y_offset", longint'(y_offset), m_y);
            chk("frame_done", longint'(frame_done), m_done);
            chk("frame_cnt", longint'(frame_cnt), m_cnt);
            chk("cfg_pending", longint'(cfg_pending), m_pend);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_start();
        ctrl_start = 1'b1; tick(); ctrl_start = 1'b0;
    endtask

    task automatic pulse_stop();
        ctrl_stop = 1'b1; tick(); ctrl_stop = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    endtask

    // Drives a w x h frame; event indexes refer to accepted pixels, the
    // last index being the frame-end cycle. Two non-accepting cycles precede it.
    task automatic frame(input int w, input int h, input int commit_at,
                         input int stop_at, input int start_at);
        int idx = 0;
        for (int ln = 0; ln < h; ln++) begin
            for (int px = 0; px < w; px++) begin
                if (px == w-1 && ln == h-1) begin
                    pix_valid = 1'b0; pix_ready = 1'b1; pix_last_x = 1'b1; pix_last_y = 1'b1; tick();
                    pix_valid = 1'b1; pix_ready = 1'b0; tick();
                end
                pix_valid  = 1'b1;
                pix_ready  = 1'b1;
                pix_last_x = (px == w-1);
                pix_last_y = (ln == h-1);
                cfg_commit = (idx == commit_at);
                ctrl_stop  = (idx == stop_at);
                ctrl_start = (idx == start_at);
                tick();
                idx++;
            end
        end
        pix_valid = 1'b0; pix_ready = 1'b0; pix_last_x = 1'b0; pix_last_y = 1'b0;
        cfg_commit = 1'b0; ctrl_stop = 1'b0; ctrl_start = 1'b0;
    endtask

    initial begin
        // Reset values
        tick(); tick();
        chk_on = 1'b1;
        tick();
        chk("rst_gen", longint'(gen_enable), 0);
        chk("rst_iter", longint'(iterations_max), 100);
        chk("rst_cnt", longint'(frame_cnt), 0);
        chk("rst_busy", longint'(busy), 0);
        aresetn = 1'b1;
        repeat (6) tick();

        // Start: enable rises one cycle after the pulse
        chk("pre_start_gen", longint'(gen_enable), 0);
        pulse_start();
        chk("start_gen", longint'(gen_enable), 1);
        chk("start_busy", longint'(busy), 1);
        chk("start_iter", longint'(iterations_max), 100);

        // Commit while running applies only at the frame end
        cfg_iter = 9'd200; cfg_x_off = 25'sd1000;
        commit();
        chk("pend_set", longint'(cfg_pending), 1);
        chk("iter_held", longint'(iterations_max), 100);
        frame(4, 2, -1, -1, -1);
        chk("t2_iter", longint'(iterations_max), 200);
        chk("t2_x", longint'(x_offset), 1000);
        chk("t2_pend", longint'(cfg_pending), 0);
        chk("t2_done", longint'(frame_done), 1);
        chk("t2_cnt", longint'(frame_cnt), 1);
        tick();
        chk("t2_done_drop", longint'(frame_done), 0);

        // Auto-pan toward the negative limit with saturation
        cfg_x_off = -(25'sd1 <<< 24) + 25'sd2; cfg_auto_en = 1'b1;
        cfg_x_step = -25'sd3; cfg_y_step = 25'sd5;
        commit();
        frame(4, 2, -1, -1, -1);
        chk("t3_apply_x", longint'(x_offset), -16777214);
        frame(4, 2, -1, -1, -1);
        chk("t3_sat1_x", longint'(x_offset), -16777216);
        chk("t3_y1", longint'(y_offset), 5);
        frame(4, 2, -1, -1, -1);
        chk("t3_sat2_x", longint'(x_offset), -16777216);
        chk("t3_y2", longint'(y_offset), 10);
        chk("t3_cnt", longint'(frame_cnt), 4);

        // Stop mid-frame: the frame completes, then generation ends
        cfg_auto_en = 1'b0; cfg_y_off = 25'sd10;
        frame(4, 2, 0, 2, -1);
        chk("t4_gen_off", longint'(gen_enable), 0);
        chk("t4_busy", longint'(busy), 0);
        chk("t4_x", longint'(x_offset), -16777214);
        chk("t4_cnt", longint'(frame_cnt), 5);

        // Start during the stopping phase cancels the stop
        pulse_start();
        frame(4, 2, -1, 1, 4);
        chk("t4_resume_gen", longint'(gen_enable), 1);
        chk("t4_resume_busy", longint'(busy), 1);

        // Commit coinciding with frame end
        cfg_iter = 9'd80;
        commit();
        cfg_iter = 9'd50;
        frame(4, 2, 7, -1, -1);
        chk("t5_iter80", longint'(iterations_max), 80);
        chk("t5_pend", longint'(cfg_pending), 1);
        frame(4, 2, -1, -1, -1);
        chk("t5_iter50", longint'(iterations_max), 50);
        chk("t5_pend_clr", longint'(cfg_pending), 0);

        // Sanitising in idle, then async reset mid-frame
        pulse_stop();
        frame(4, 2, -1, -1, -1);
        chk("t6_idle", longint'(busy), 0);
        cfg_iter = 9'd0; cfg_zoom = 3'd7;
        commit();
        chk("t6_iter", longint'(iterations_max), 1);
        chk("t6_zoom", longint'(zoom), 5);
        chk("t6_pend", longint'(cfg_pending), 0);
        pulse_start();
        pix_valid = 1'b1; pix_ready = 1'b1;
        tick(); tick();
        #2 aresetn = 1'b0;
        #1;
        chk("arst_gen", longint'(gen_enable), 0);
        chk("arst_iter", longint'(iterations_max), 100);
        chk("arst_zoom", longint'(zoom), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_pend", longint'(cfg_pending), 0);
        pix_valid = 1'b0; pix_ready = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();

        // Simultaneous start/stop priority, then counter wrap
        ctrl_start = 1'b1; ctrl_stop = 1'b1;
        tick();
        chk("both_idle_gen", longint'(gen_enable), 1);
        tick();
        tick();
        ctrl_start = 1'b0; ctrl_stop = 1'b0;
        for (int f = 0; f < 16; f++) frame(1, 1, -1, -1, -1);
        chk("wrap_cnt0", longint'(frame_cnt), 0);
        chk("wrap_busy", longint'(busy), 1);
        frame(1, 1, -1, -1, -1);
        chk("wrap_cnt1", longint'(frame_cnt), 1);
        tick();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
